// File: rtl/sd_clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sd_clk_pkg
// Shared constants and types for the SD bus clock controller.
//   SYS_CLK_HZ : system clock frequency the dividers are relative to
//   ID_DIV     : divider used after reset (50 MHz / 125 = 400 kHz)
//   MIN_DIV    : smallest legal divider
//   WAIT_MAX   : clk cycles to wait for the count generator to answer
//   state_t    : switch sequencer states
// ---------------------------------------------------------------------------
package sd_clk_pkg;

    localparam int          SYS_CLK_HZ = 50_000_000;
    localparam logic [15:0] ID_DIV     = 16'd125;
    localparam logic [15:0] MIN_DIV    = 16'd2;
    localparam int          WAIT_MAX   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        ALIGN = 2'd3
    } state_t;

    // Raise a returned count to the smallest divider that still gives a
    // high and a low phase of at least one cycle each.
    function automatic logic [15:0] clamp_div(input logic [15:0] count,
                                              input logic [15:0] min_div);
        return (count < min_div) ? min_div : count;
    endfunction

endpackage

// File: rtl/sd_clk_ctrl_if.sv
// ---------------------------------------------------------------------------
// sd_clk_ctrl_if
// Handshake between the clock controller and the external
// clk_div_count_generator.
//   cg_tran_speed : TRAN_SPEED byte presented to the generator
//   cg_start      : one-cycle start pulse
//   cg_ok         : generator finished, cg_count valid
//   cg_err        : generator error
//   cg_count      : divider result
// master = clock controller, slave = count generator.
// ---------------------------------------------------------------------------
interface sd_clk_ctrl_if;

    logic [7:0]  cg_tran_speed;
    logic        cg_start;
    logic        cg_ok;
    logic        cg_err;
    logic [15:0] cg_count;

    modport master (
        output cg_tran_speed,
        output cg_start,
        input  cg_ok,
        input  cg_err,
        input  cg_count
    );

    modport slave (
        input  cg_tran_speed,
        input  cg_start,
        output cg_ok,
        output cg_err,
        output cg_count
    );

endinterface

// File: rtl/sd_clk_ctrl_phase_gen.sv
// ---------------------------------------------------------------------------
// sd_clk_phase_gen
// Phase counter that produces the SD bus clock from the system clock.
//   clk, reset  : system clock, synchronous active-high reset
//   clk_en      : 1 = sd_clk may run, sampled only at a period boundary
//   load, div   : replace the divider at the current boundary
//   cur_div     : divider in use
//   sd_clk      : registered bus clock, high for cnt < cur_div/2
//   sd_rise/fall: strobes in the cycles sd_clk goes high / low
//   at_boundary : last cycle of a period, or any cycle while parked
// ---------------------------------------------------------------------------
module sd_clk_phase_gen #(
    parameter logic [15:0] RESET_DIV = 16'd125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        load,
    input  logic [15:0] div,
    output logic [15:0] cur_div,
    output logic        sd_clk,
    output logic        sd_rise,
    output logic        sd_fall,
    output logic        at_boundary
);

    logic [15:0] cnt;
    logic [15:0] cnt_next;
    logic [15:0] div_next;
    logic        running;
    logic        running_next;

    // While parked every cycle is a boundary, so clk_en and a pending load
    // are picked up on the very next edge.
    assign at_boundary = !running || (cnt == cur_div - 16'd1);

    always_comb begin
        // NOTE: every variable gets a default before the branches, so no
        // path leaves one unassigned and no latch is inferred.
        cnt_next     = cnt + 16'd1;
        running_next = running;
        div_next     = cur_div;
        if (at_boundary) begin
            cnt_next     = '0;
            running_next = clk_en;
            if (load) begin
                div_next = div;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            running <= 1'b0;
            cur_div <= RESET_DIV;
            sd_clk  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            cnt     <= cnt_next;
            running <= running_next;
            cur_div <= div_next;
            // Derived from the next counter state so sd_clk lines up with
            // cnt instead of trailing it by a cycle.
            sd_clk  <= running_next && (cnt_next < (div_next >> 1));
        end
    end

    assign sd_rise = running && (cnt == '0);
    assign sd_fall = running && (cnt == (cur_div >> 1));

endmodule

// File: rtl/sd_clk_ctrl.sv
// ---------------------------------------------------------------------------
// sd_clk_ctrl
// Owns the SD bus clock. Starts at the identification divider, sequences the
// external count generator when a new TRAN_SPEED byte arrives, and swaps in
// the returned divider only at a period boundary so sd_clk never glitches.
//   clk, reset        : 50 MHz system clock, synchronous active-high reset
//   speed_req         : one-cycle request, tran_speed valid
//   tran_speed        : CSD TRAN_SPEED byte
//   cg                : count generator handshake (master side)
//   clk_en            : 1 = run sd_clk, 0 = park it low at the next boundary
//   sd_clk            : SD bus clock
//   sd_rise, sd_fall  : edge strobes for the command/data engines
//   cur_div           : divider in use
//   busy              : a switch is in progress
//   switch_done       : new divider takes effect
//   switch_err        : generator error, zero count or timeout
// ---------------------------------------------------------------------------
module sd_clk_ctrl #(
    parameter logic [15:0] ID_DIV   = sd_clk_pkg::ID_DIV,
    parameter logic [15:0] MIN_DIV  = sd_clk_pkg::MIN_DIV,
    parameter int          WAIT_MAX = sd_clk_pkg::WAIT_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                speed_req,
    input  logic [7:0]          tran_speed,
    sd_clk_ctrl_if.master       cg,
    input  logic                clk_en,
    output logic                sd_clk,
    output logic                sd_rise,
    output logic                sd_fall,
    output logic [15:0]         cur_div,
    output logic                busy,
    output logic                switch_done,
    output logic                switch_err
);

    import sd_clk_pkg::*;

    state_t      state;
    state_t      state_next;
    logic [15:0] new_div;
    logic [15:0] wait_cnt;
    logic        at_boundary;
    logic        load;
    logic        cg_fail;
    logic        timeout;

    // ok and err together counts as an error, as does a zero divider.
    assign cg_fail = cg.cg_err || (cg.cg_ok && (cg.cg_count == '0));
    // wait_cnt is 0 in the first WAIT cycle, so this fires in the
    // WAIT_MAX-th cycle after cg_start.
    assign timeout = (wait_cnt == 16'(WAIT_MAX - 1));

    sd_clk_phase_gen #(
        .RESET_DIV (ID_DIV)
    ) u_phase_gen (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .load        (load),
        .div         (new_div),
        .cur_div     (cur_div),
        .sd_clk      (sd_clk),
        .sd_rise     (sd_rise),
        .sd_fall     (sd_fall),
        .at_boundary (at_boundary)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cg.cg_tran_speed <= '0;
            new_div          <= ID_DIV;
            wait_cnt         <= '0;
        end else begin
            if ((state == IDLE) && speed_req) begin
                cg.cg_tran_speed <= tran_speed;
            end
            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if ((state == WAIT) && cg.cg_ok && !cg_fail) begin
                new_div <= clamp_div(cg.cg_count, MIN_DIV);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (speed_req) state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (cg_fail)       state_next = IDLE;
                else if (cg.cg_ok) state_next = ALIGN;
                else if (timeout)  state_next = IDLE;
            end
            ALIGN: if (at_boundary) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy drops in the same cycle the completion or error strobe fires.
    always_comb begin
        cg.cg_start = 1'b0;
        busy        = 1'b0;
        switch_done = 1'b0;
        switch_err  = 1'b0;
        load        = 1'b0;
        case (state)
            START: begin
                cg.cg_start = 1'b1;
                busy        = 1'b1;
            end
            WAIT: begin
                switch_err = cg_fail || (!cg.cg_ok && timeout);
                busy       = !switch_err;
            end
            ALIGN: begin
                switch_done = at_boundary;
                load        = at_boundary;
                busy        = !at_boundary;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sd_clk_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sd_clk_ctrl
// Bench for sd_clk_ctrl. The bench plays the count generator. A reference
// model tracks the position inside the current sd_clk period and the cycle
// number at which a speed request was accepted, and predicts every output
// each cycle from those plain numbers.
// ---------------------------------------------------------------------------
module tb_sd_clk_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        speed_req = 1'b0;
    logic [7:0]  tran_speed = 8'h00;
    logic        clk_en = 1'b0;
    logic        sd_clk;
    logic        sd_rise;
    logic        sd_fall;
    logic [15:0] cur_div;
    logic        busy;
    logic        switch_done;
    logic        switch_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    sd_clk_ctrl_if cg();

    sd_clk_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .speed_req   (speed_req),
        .tran_speed  (tran_speed),
        .cg          (cg),
        .clk_en      (clk_en),
        .sd_clk      (sd_clk),
        .sd_rise     (sd_rise),
        .sd_fall     (sd_fall),
        .cur_div     (cur_div),
        .busy        (busy),
        .switch_done (switch_done),
        .switch_err  (switch_err)
    );

    always #10 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    //   m_pos  : cycles since the current sd_clk period began, -1 = parked
    //   m_req  : cycle in which a speed request was accepted, -1 = none
    //   m_pend : divider waiting for the next boundary, 0 = none
    // ------------------------------------------------------------------
    int         m_div  = 125;
    int         m_pos  = -1;
    int         m_req  = -1;
    int         m_pend = 0;
    logic [7:0] m_ts   = 8'h00;
    bit         mon_en = 1'b0;

    function automatic void model_flags(output bit bnd, output bit inw,
                                        output bit err, output bit done);
        bnd  = (m_pos < 0) || (m_pos == m_div - 1);
        inw  = (m_req >= 0) && (m_pend == 0) && (cyc >= m_req + 2);
        err  = inw && (cg.cg_err || (cg.cg_ok && cg.cg_count == 16'd0) ||
                       (!cg.cg_ok && cyc == m_req + 65));
        done = (m_pend != 0) && bnd;
    endfunction

    always @(posedge clk) begin
        bit bnd, inw, err, done;
        model_flags(bnd, inw, err, done);
        if (reset) begin
            m_div = 125; m_pos = -1; m_req = -1; m_pend = 0; m_ts = 8'h00;
        end else begin
            if (bnd) begin
                if (done) m_div = m_pend;
                m_pos = clk_en ? 0 : -1;
            end else begin
                m_pos++;
            end
            if (m_req < 0) begin
                if (speed_req) begin
                    m_req = cyc;
                    m_ts  = tran_speed;
                end
            end else if (err || done) begin
                m_req  = -1;
                m_pend = 0;
            end else if (inw && cg.cg_ok) begin
                m_pend = (cg.cg_count < 16'd2) ? 2 : int'(cg.cg_count);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit bnd, inw, err, done;
        logic [30:0] exp_v, act_v;
        if (mon_en) begin
            model_flags(bnd, inw, err, done);
            exp_v = {(m_pos >= 0) && (m_pos < m_div / 2), m_pos == 0,
                     m_pos == m_div / 2, (m_req >= 0) && (cyc == m_req + 1),
                     (m_req >= 0) && !err && !done, done, err,
                     16'(m_div), m_ts};
            act_v = {sd_clk, sd_rise, sd_fall, cg.cg_start, busy,
                     switch_done, switch_err, cur_div, cg.cg_tran_speed};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_bad++;
                $display("FAIL model cyc=%0d got=%h expected=%h (clk,rise,fall,start,busy,done,err,div,ts)",
                         cyc, act_v, exp_v);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [7:0] ts, output int r);
        speed_req  = 1'b1;
        tran_speed = ts;
        r          = cyc;
        tick();
        speed_req  = 1'b0;
        tran_speed = 8'($urandom);
    endtask

    task automatic respond(input bit ok, input bit err, input logic [15:0] cnt);
        cg.cg_ok    = ok;
        cg.cg_err   = err;
        cg.cg_count = cnt;
        tick();
        cg.cg_ok    = 1'b0;
        cg.cg_err   = 1'b0;
        cg.cg_count = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (!busy) got = 1'b1;
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; clk_en = 1'b0; speed_req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sd_clk, sd_rise, sd_fall, cg.cg_start, busy, switch_done, switch_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_strobes got=%b expected=0000000",
                     {sd_clk, sd_rise, sd_fall, cg.cg_start, busy, switch_done, switch_err});
        end
        n_cmp++;
        if (cur_div !== 16'd125) begin
            n_bad++; $display("FAIL reset_cur_div got=%0d expected=125", cur_div);
        end
        n_cmp++;
        if (cg.cg_tran_speed !== 8'h00) begin
            n_bad++; $display("FAIL reset_tran_speed got=%h expected=00", cg.cg_tran_speed);
        end
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_id_clock();
        int c0, first, second, high;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (sd_clk !== 1'b0 || sd_rise !== 1'b0) begin
                n_bad++; $display("FAIL parked_low got clk=%b rise=%b expected 0 0", sd_clk, sd_rise);
            end
            tick();
        end
        clk_en = 1'b1;
        c0 = cyc; first = -1; second = -1; high = 0;
        for (int i = 0; i < 300 && second < 0; i++) begin
            @(negedge clk);
            if (sd_rise === 1'b1) begin
                if (first < 0) first = cyc;
                else           second = cyc;
            end
            if (first >= 0 && second < 0 && sd_clk === 1'b1) high++;
            tick();
        end
        n_cmp++;
        if (first != c0 + 1) begin
            n_bad++; $display("FAIL first_rise got cycle %0d expected %0d", first, c0 + 1);
        end
        n_cmp++;
        if (second - first != 125) begin
            n_bad++; $display("FAIL id_period got=%0d expected=125", second - first);
        end
        n_cmp++;
        if (high != 62) begin
            n_bad++; $display("FAIL id_high got=%0d expected=62", high);
        end
        n_cmp++;
        if (cur_div !== 16'd125) begin
            n_bad++; $display("FAIL id_cur_div got=%0d expected=125", cur_div);
        end
    endtask

    task automatic test_switch_fast();
        int r, dc, starts;
        request(8'h32, r);
        @(negedge clk);
        n_cmp++;
        if (cg.cg_start !== 1'b1) begin
            n_bad++; $display("FAIL start_pulse got=%b expected=1", cg.cg_start);
        end
        n_cmp++;
        if (cg.cg_tran_speed !== 8'h32) begin
            n_bad++; $display("FAIL cg_tran_speed got=%h expected=32", cg.cg_tran_speed);
        end
        starts = int'(cg.cg_start === 1'b1);
        tick();
        repeat (39) begin
            @(negedge clk);
            starts += int'(cg.cg_start === 1'b1);
            tick();
        end
        respond(1'b1, 1'b0, 16'd2);
        dc = -1;
        for (int i = 0; i < 200 && dc < 0; i++) begin
            @(negedge clk);
            starts += int'(cg.cg_start === 1'b1);
            if (switch_done === 1'b1) begin
                dc = cyc;
                n_cmp++;
                if (cur_div !== 16'd125) begin
                    n_bad++; $display("FAIL div_before_boundary got=%0d expected=125", cur_div);
                end
            end
            tick();
        end
        n_cmp++;
        if (dc < 0) begin
            n_bad++; $display("FAIL switch_done_seen got=none expected=pulse");
        end
        n_cmp++;
        if (starts != 1) begin
            n_bad++; $display("FAIL start_count got=%0d expected=1", starts);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_cmp++;
            if (sd_clk !== ((i % 2) == 0) || cur_div !== 16'd2) begin
                n_bad++;
                $display("FAIL div2_toggle i=%0d got clk=%b div=%0d expected clk=%b div=2",
                         i, sd_clk, cur_div, (i % 2) == 0);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int r, kind, dly;
        logic [15:0] cnt;
        logic [15:0] exp_div;
        bit got;
        exp_div = 16'd2;
        for (int k = 0; k < 6; k++) begin
            kind = (k == 5) ? 0 : int'($urandom_range(0, 3));
            cnt  = 16'($urandom_range(3, 24));
            dly  = int'($urandom_range(0, 50));
            request(8'($urandom), r);
            repeat (dly + 1) tick();
            case (kind)
                2:       respond(1'b0, 1'b1, cnt);
                3:       respond(1'b1, 1'b0, 16'd0);
                default: begin respond(1'b1, 1'b0, cnt); exp_div = cnt; end
            endcase
            wait_idle(100, got);
            n_cmp++;
            if (!got) begin
                n_bad++; $display("FAIL random_idle k=%0d got=busy expected=idle", k);
            end
            @(negedge clk);
            n_cmp++;
            if (cur_div !== exp_div) begin
                n_bad++; $display("FAIL random_div k=%0d got=%0d expected=%0d", k, cur_div, exp_div);
            end
            tick();
        end
    endtask

    task automatic test_clamp();
        int r;
        bit seen;
        request(8'h5A, r);
        repeat (1 + int'($urandom_range(0, 30))) tick();
        respond(1'b1, 1'b0, 16'd1);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (switch_done === 1'b1) seen = 1'b1;
            tick();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL clamp_done got=none expected=pulse");
        end
        @(negedge clk);
        n_cmp++;
        if (cur_div !== 16'd2) begin
            n_bad++; $display("FAIL clamp_div got=%0d expected=2", cur_div);
        end
        tick();
    endtask

    task automatic test_error();
        int r;
        for (int v = 0; v < 3; v++) begin
            request((v == 0) ? 8'h00 : 8'($urandom), r);
            repeat (1 + int'($urandom_range(0, 20))) tick();
            cg.cg_ok    = (v != 0);
            cg.cg_err   = (v != 1);
            cg.cg_count = (v == 1) ? 16'd0 : 16'd9;
            @(negedge clk);
            n_cmp++;
            if (switch_err !== 1'b1 || busy !== 1'b0 || switch_done !== 1'b0) begin
                n_bad++;
                $display("FAIL error_pulse v=%0d got err=%b busy=%b done=%b expected 1 0 0",
                         v, switch_err, busy, switch_done);
            end
            tick();
            cg.cg_ok = 1'b0; cg.cg_err = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (cur_div !== 16'd2 || busy !== 1'b0) begin
                n_bad++; $display("FAIL error_keep v=%0d got div=%0d busy=%b expected 2 0", v, cur_div, busy);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int r, s, ec, starts;
        request(8'h19, r);
        @(negedge clk);
        s = cyc;
        starts = int'(cg.cg_start === 1'b1);
        tick();
        ec = -1;
        for (int i = 0; i < 120 && ec < 0; i++) begin
            speed_req  = (cyc == s + 10);
            tran_speed = 8'h77;
            @(negedge clk);
            starts += int'(cg.cg_start === 1'b1);
            if (switch_err === 1'b1) ec = cyc;
            tick();
        end
        speed_req = 1'b0;
        n_cmp++;
        if (ec != s + 64) begin
            n_bad++; $display("FAIL timeout_cycle got=%0d expected=%0d", ec - s, 64);
        end
        n_cmp++;
        if (starts != 1) begin
            n_bad++; $display("FAIL timeout_starts got=%0d expected=1", starts);
        end
        n_cmp++;
        if (cg.cg_tran_speed !== 8'h19 || cur_div !== 16'd2) begin
            n_bad++;
            $display("FAIL timeout_keep got ts=%h div=%0d expected 19 2", cg.cg_tran_speed, cur_div);
        end
    endtask

    task automatic test_gating();
        int r, rc, high, rises, fc;
        bit got;
        request(8'h2B, r);
        tick();
        respond(1'b1, 1'b0, 16'd20);
        wait_idle(60, got);
        rc = -1;
        for (int i = 0; i < 60 && rc < 0; i++) begin
            @(negedge clk);
            if (sd_rise === 1'b1) rc = cyc;
            tick();
        end
        repeat (4) tick();
        clk_en = 1'b0;
        high = 0; rises = 0; fc = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (sd_clk === 1'b1) high++;
            if (sd_rise === 1'b1) rises++;
            if (sd_fall === 1'b1) fc = cyc;
            tick();
        end
        n_cmp++;
        if (rc < 0 || high != 5) begin
            n_bad++; $display("FAIL gate_high got=%0d expected=5", high);
        end
        n_cmp++;
        if (rises != 0 || fc != rc + 10) begin
            n_bad++;
            $display("FAIL gate_park got rises=%0d fall_at=%0d expected 0 %0d", rises, fc - rc, 10);
        end
    endtask

    task automatic test_reset_align();
        int r, rc, dones;
        clk_en = 1'b1;
        request(8'hC8, r);
        rc = -1;
        for (int i = 0; i < 60 && rc < 0; i++) begin
            @(negedge clk);
            if (sd_rise === 1'b1 && cyc >= r + 2) rc = cyc;
            tick();
        end
        respond(1'b1, 1'b0, 16'd40);
        @(negedge clk);
        n_cmp++;
        if (rc < 0 || busy !== 1'b1 || cur_div !== 16'd20) begin
            n_bad++; $display("FAIL align_busy got busy=%b div=%0d expected 1 20", busy, cur_div);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({sd_clk, sd_rise, sd_fall, cg.cg_start, busy, switch_done, switch_err} !== 7'b0 ||
            cur_div !== 16'd125 || cg.cg_tran_speed !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid_align got flags=%b div=%0d ts=%h expected 0000000 125 00",
                     {sd_clk, sd_rise, sd_fall, cg.cg_start, busy, switch_done, switch_err},
                     cur_div, cg.cg_tran_speed);
        end
        tick();
        respond(1'b1, 1'b0, 16'd5);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            dones += int'(switch_done === 1'b1 || busy === 1'b1);
            tick();
        end
        n_cmp++;
        if (dones != 0 || cur_div !== 16'd125) begin
            n_bad++; $display("FAIL stale_ok got events=%0d div=%0d expected 0 125", dones, cur_div);
        end
    endtask

    initial begin
        cg.cg_ok    = 1'b0;
        cg.cg_err   = 1'b0;
        cg.cg_count = 16'd0;
        test_reset();
        test_id_clock();
        test_switch_fast();
        test_random();
        test_clamp();
        test_error();
        test_timeout();
        test_gating();
        test_reset_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
